// File: rtl/sc_mon_if.sv
// Monitor-side bundle for sc_mon: the sampled counter value and control inputs,
// plus the checker's registered status outputs.
// Ports: master drives cnt_in/ctr_rst/clr_err and observes the status; slave is the checker.
interface sc_mon_if #(
    parameter int WIDTH = 3,
    parameter int ERRW  = 8
) ();
    logic [WIDTH-1:0] cnt_in;      // counter's registered output
    logic             ctr_rst;     // counter's clear request
    logic             clr_err;     // clears sticky flag and error count
    logic             err;         // one-cycle violation pulse
    logic             err_sticky;  // latched violation flag
    logic [ERRW-1:0]  err_cnt;     // saturating violation count
    logic             locked;      // tracking (COUNT or HOLD)
    logic             sat;         // tracking at the saturation value

    modport master (
        output cnt_in, ctr_rst, clr_err,
        input  err, err_sticky, err_cnt, locked, sat
    );

    modport slave (
        input  cnt_in, ctr_rst, clr_err,
        output err, err_sticky, err_cnt, locked, sat
    );
endinterface

// File: rtl/sc_mon.sv
// Passive sequence checker for a saturating step counter; predicts each sample and flags violations.
// Latency: all outputs registered, one cycle after the sampled cnt_in/ctr_rst. No input-to-output comb path.
// Backpressure: none; purely observes, never stalls or drives the counter.
// Ports: clk, rst (sync, active-low), mon (sc_mon_if.slave: cnt_in, ctr_rst, clr_err in;
//        err, err_sticky, err_cnt, locked, sat out).
module sc_mon #(
    parameter int WIDTH = 3,
    parameter int MAX   = 5,
    parameter int ERRW  = 8
) (
    input  logic     clk,
    input  logic     rst,
    sc_mon_if.slave  mon
);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [WIDTH:0]  MAX_W   = (WIDTH+1)'(MAX);
    localparam logic [ERRW-1:0] ERR_SAT = '1;

    state_t          state;
    logic [WIDTH:0]  exp_q;      // expected cnt_in for the current cycle
    logic            clr_d;      // ctr_rst delayed one cycle
    logic            err_q;
    logic            sticky_q;
    logic [ERRW-1:0] err_cnt_q;
    logic            locked_q;
    logic            sat_q;

    logic [WIDTH:0]  cnt_w;
    logic [WIDTH:0]  cur_exp;
    logic [WIDTH:0]  inc_w;
    logic [WIDTH:0]  load_val;
    logic            match;
    logic            to_hold;
    logic            viol;

    // Prediction arithmetic is one bit wider than the count so the +1 never wraps.
    always_comb begin
        cnt_w    = {1'b0, mon.cnt_in};
        // A clear seen last cycle forces the counter to 0 now, whatever exp holds.
        cur_exp  = clr_d ? '0 : exp_q;
        inc_w    = (cur_exp < MAX_W) ? cur_exp + (WIDTH+1)'(1) : MAX_W;
        match    = (cnt_w == cur_exp);
        // The counter clears on the same edge that samples ctr_rst, so a clear
        // sampled now makes 0 the only legal value next cycle.
        load_val = mon.ctr_rst ? '0 : inc_w;
        to_hold  = (cnt_w == MAX_W) && !mon.ctr_rst && !clr_d;
    end

    always_comb begin
        viol = 1'b0;
        case (state)
            SYNC:        viol = (cnt_w > MAX_W);
            COUNT, HOLD: viol = !match;
            default:     viol = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= SYNC;
            exp_q     <= '0;
            clr_d     <= 1'b0;
            err_q     <= 1'b0;
            sticky_q  <= 1'b0;
            err_cnt_q <= '0;
            locked_q  <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            clr_d <= mon.ctr_rst;
            err_q <= viol;

            case (state)
                SYNC: begin
                    // Only a 0 sample can establish lock; values above MAX are
                    // illegal outright, anything else is waited out silently.
                    if (cnt_w == '0) begin
                        state    <= COUNT;
                        exp_q    <= mon.ctr_rst ? '0 : (WIDTH+1)'(1);
                        locked_q <= 1'b1;
                        sat_q    <= 1'b0;
                    end
                end
                COUNT, HOLD: begin
                    if (match) begin
                        exp_q    <= load_val;
                        locked_q <= 1'b1;
                        if (to_hold) begin
                            state <= HOLD;
                            sat_q <= 1'b1;
                        end else begin
                            state <= COUNT;
                            sat_q <= 1'b0;
                        end
                    end else begin
                        state    <= SYNC;
                        locked_q <= 1'b0;
                        sat_q    <= 1'b0;
                    end
                end
                default: begin
                    state    <= SYNC;
                    locked_q <= 1'b0;
                    sat_q    <= 1'b0;
                end
            endcase

            // A violation in the same cycle as clr_err wins: history restarts at one.
            if (viol) begin
                sticky_q <= 1'b1;
                if (mon.clr_err) begin
                    err_cnt_q <= ERRW'(1);
                end else if (err_cnt_q != ERR_SAT) begin
                    err_cnt_q <= err_cnt_q + ERRW'(1);
                end
            end else if (mon.clr_err) begin
                sticky_q  <= 1'b0;
                err_cnt_q <= '0;
            end
        end
    end

    assign mon.err        = err_q;
    assign mon.err_sticky = sticky_q;
    assign mon.err_cnt    = err_cnt_q;
    assign mon.locked     = locked_q;
    assign mon.sat        = sat_q;

endmodule

// File: tb/tb_sc_mon.sv
// Bench for sc_mon: a directed table of hand-derived vectors followed by
// randomized counter-like stimulus checked against a behavioural model.
// Two instances share stimulus: ERRW=8 and ERRW=2 (error-count saturation).
module tb_sc_mon;

    localparam int WIDTH = 3;
    localparam int MAX   = 5;

    logic clk;
    logic rst;

    sc_mon_if #(.WIDTH(WIDTH), .ERRW(8)) bus ();
    sc_mon_if #(.WIDTH(WIDTH), .ERRW(2)) bus2 ();

    assign bus2.cnt_in  = bus.cnt_in;
    assign bus2.ctr_rst = bus.ctr_rst;
    assign bus2.clr_err = bus.clr_err;

    sc_mon #(.WIDTH(WIDTH), .MAX(MAX), .ERRW(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .mon (bus.slave)
    );

    sc_mon #(.WIDTH(WIDTH), .MAX(MAX), .ERRW(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .mon (bus2.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst;
        logic [2:0] cnt;
        logic       cr;
        logic       ce;
        logic       e_err;
        logic       e_stk;
        logic [7:0] e_ec;
        logic [1:0] e_ec2;
        logic       e_lk;
        logic       e_sat;
    } vec_t;

    vec_t tbl[$];

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model: "locked" plus the value the counter must show next.
    bit m_lock, m_hold, m_err, m_stk;
    int m_exp, m_ec, m_ec2;

    task automatic chk(input string nm, input int act, input int expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    endtask

    task automatic add(input logic r, input int c, input logic cr, input logic ce,
                       input logic er, input logic st, input int ec, input int ec2,
                       input logic lk, input logic sa);
        vec_t v;
        v.rst = r; v.cnt = 3'(c); v.cr = cr; v.ce = ce;
        v.e_err = er; v.e_stk = st; v.e_ec = 8'(ec); v.e_ec2 = 2'(ec2);
        v.e_lk = lk; v.e_sat = sa;
        tbl.push_back(v);
    endtask

    function automatic int sat_inc(input int v, input int lim);
        return (v + 1 > lim) ? lim : v + 1;
    endfunction

    task automatic model_step(input logic r, input int c, input logic cr, input logic ce);
        bit v;
        if (!r) begin
            m_lock = 0; m_hold = 0; m_err = 0; m_stk = 0;
            m_exp = 0; m_ec = 0; m_ec2 = 0;
            return;
        end
        v = 0;
        if (!m_lock) begin
            if (c == 0) begin
                m_lock = 1; m_hold = 0;
                m_exp  = cr ? 0 : 1;
            end else if (c > MAX) begin
                v = 1;
            end
        end else if (c == m_exp) begin
            m_hold = (c == MAX) && !cr;
            m_exp  = cr ? 0 : sat_inc(m_exp, MAX);
        end else begin
            v = 1; m_lock = 0; m_hold = 0;
        end
        m_err = v;
        if (v) begin
            m_stk = 1;
            m_ec  = ce ? 1 : sat_inc(m_ec, 255);
            m_ec2 = ce ? 1 : sat_inc(m_ec2, 3);
        end else if (ce) begin
            m_stk = 0; m_ec = 0; m_ec2 = 0;
        end
    endtask

    // Apply inputs, advance one edge, update the model, sample 1 ns later.
    task automatic cycle(input logic r, input int c, input logic cr, input logic ce);
        rst         = r;
        bus.cnt_in  = 3'(c);
        bus.ctr_rst = cr;
        bus.clr_err = ce;
        @(posedge clk);
        model_step(r, c, cr, ce);
        #1;
    endtask

    initial begin
        rst = 1'b0; bus.cnt_in = '0; bus.ctr_rst = 1'b0; bus.clr_err = 1'b0;
        m_lock = 0; m_hold = 0; m_err = 0; m_stk = 0; m_exp = 0; m_ec = 0; m_ec2 = 0;

        //   rst cnt cr ce | err stk ec ec2 lk sat
        add(0, 0, 0, 0,   0, 0, 0, 0, 0, 0);   // reset
        add(0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0,   0, 0, 0, 0, 1, 0);   // lock on 0
        add(1, 1, 0, 0,   0, 0, 0, 0, 1, 0);
        add(1, 2, 0, 0,   0, 0, 0, 0, 1, 0);
        add(1, 3, 0, 0,   0, 0, 0, 0, 1, 0);
        add(1, 4, 0, 0,   0, 0, 0, 0, 1, 0);
        add(1, 5, 0, 0,   0, 0, 0, 0, 1, 1);   // HOLD
        add(1, 5, 0, 0,   0, 0, 0, 0, 1, 1);
        add(1, 5, 0, 0,   0, 0, 0, 0, 1, 1);
        add(1, 5, 1, 0,   0, 0, 0, 0, 1, 0);   // clear from HOLD
        add(1, 0, 0, 0,   0, 0, 0, 0, 1, 0);
        add(1, 1, 0, 0,   0, 0, 0, 0, 1, 0);
        add(1, 2, 0, 0,   0, 0, 0, 0, 1, 0);
        add(1, 3, 1, 0,   0, 0, 0, 0, 1, 0);   // clear mid-count
        add(1, 0, 0, 0,   0, 0, 0, 0, 1, 0);
        add(1, 1, 0, 0,   0, 0, 0, 0, 1, 0);
        add(1, 2, 0, 0,   0, 0, 0, 0, 1, 0);
        add(1, 3, 1, 0,   0, 0, 0, 0, 1, 0);
        add(1, 4, 0, 0,   1, 1, 1, 1, 0, 0);   // ignored clear -> violation
        add(1, 4, 0, 0,   0, 1, 1, 1, 0, 0);   // SYNC, legal value, no error
        add(1, 0, 0, 0,   0, 1, 1, 1, 1, 0);
        add(1, 1, 0, 0,   0, 1, 1, 1, 1, 0);
        add(1, 2, 0, 0,   0, 1, 1, 1, 1, 0);
        add(1, 4, 0, 0,   1, 1, 2, 2, 0, 0);   // skip
        add(1, 6, 0, 0,   1, 1, 3, 3, 0, 0);   // illegal in SYNC
        add(1, 0, 0, 0,   0, 1, 3, 3, 1, 0);   // re-lock
        add(1, 1, 0, 0,   0, 1, 3, 3, 1, 0);
        add(1, 2, 0, 0,   0, 1, 3, 3, 1, 0);
        add(1, 3, 0, 0,   0, 1, 3, 3, 1, 0);
        add(1, 4, 0, 0,   0, 1, 3, 3, 1, 0);
        add(1, 5, 0, 0,   0, 1, 3, 3, 1, 1);
        add(1, 0, 0, 0,   1, 1, 4, 3, 0, 0);   // wrap from HOLD is illegal
        add(1, 0, 0, 0,   0, 1, 4, 3, 1, 0);
        add(1, 1, 0, 0,   0, 1, 4, 3, 1, 0);   // exp was 1
        add(1, 2, 0, 1,   0, 0, 0, 0, 1, 0);   // clr_err alone
        add(1, 5, 0, 1,   1, 1, 1, 1, 0, 0);   // clr_err + violation
        add(1, 0, 0, 0,   0, 1, 1, 1, 1, 0);
        add(1, 1, 0, 0,   0, 1, 1, 1, 1, 0);
        add(1, 2, 0, 0,   0, 1, 1, 1, 1, 0);
        add(1, 3, 0, 0,   0, 1, 1, 1, 1, 0);
        add(1, 4, 0, 0,   0, 1, 1, 1, 1, 0);
        add(1, 5, 0, 0,   0, 1, 1, 1, 1, 1);
        add(0, 5, 0, 0,   0, 0, 0, 0, 0, 0);   // reset from HOLD + sticky
        add(1, 3, 0, 0,   0, 0, 0, 0, 0, 0);
        add(1, 7, 0, 0,   1, 1, 1, 1, 0, 0);   // repeated violations
        add(1, 7, 0, 0,   1, 1, 2, 2, 0, 0);
        add(1, 7, 0, 0,   1, 1, 3, 3, 0, 0);
        add(1, 7, 0, 0,   1, 1, 4, 3, 0, 0);
        add(1, 7, 0, 0,   1, 1, 5, 3, 0, 0);
        add(1, 2, 0, 1,   0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0,   0, 0, 0, 0, 1, 0);   // ctr_rst held
        add(1, 0, 1, 0,   0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0,   0, 0, 0, 0, 1, 0);
        add(1, 1, 0, 0,   0, 0, 0, 0, 1, 0);
        add(1, 2, 0, 0,   0, 0, 0, 0, 1, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].rst, int'(tbl[i].cnt), tbl[i].cr, tbl[i].ce);
            chk($sformatf("row%0d_err", i),     int'(bus.err),        int'(tbl[i].e_err));
            chk($sformatf("row%0d_sticky", i),  int'(bus.err_sticky), int'(tbl[i].e_stk));
            chk($sformatf("row%0d_err_cnt", i), int'(bus.err_cnt),    int'(tbl[i].e_ec));
            chk($sformatf("row%0d_err_cnt2", i), int'(bus2.err_cnt),  int'(tbl[i].e_ec2));
            chk($sformatf("row%0d_locked", i),  int'(bus.locked),     int'(tbl[i].e_lk));
            chk($sformatf("row%0d_sat", i),     int'(bus.sat),        int'(tbl[i].e_sat));
        end

        // Random phase: a well-behaved counter with occasional corrupted samples.
        begin
            int c;
            c = 3;
            for (int k = 0; k < 3000; k++) begin
                logic r, cr, ce;
                int s;
                r  = ($urandom_range(0, 99) != 0);
                cr = ($urandom_range(0, 9) == 0);
                ce = ($urandom_range(0, 19) == 0);
                s  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 7)) : c;
                cycle(r, s, cr, ce);
                c = cr ? 0 : sat_inc(c, MAX);
                chk($sformatf("rnd%0d_err", k),      int'(bus.err),        int'(m_err));
                chk($sformatf("rnd%0d_sticky", k),   int'(bus.err_sticky), int'(m_stk));
                chk($sformatf("rnd%0d_err_cnt", k),  int'(bus.err_cnt),    m_ec);
                chk($sformatf("rnd%0d_err_cnt2", k), int'(bus2.err_cnt),   m_ec2);
                chk($sformatf("rnd%0d_locked", k),   int'(bus.locked),     int'(m_lock));
                chk($sformatf("rnd%0d_sat", k),      int'(bus.sat),        int'(m_hold));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
